// File: rtl/shift_rows_stage.sv
// -----------------------------------------------------------------------------
// shift_rows_stage
// Registered AES ShiftRows stage with a 2-entry valid/ready FIFO.
// The incoming substituted state is permuted combinationally and the permuted
// value is what gets stored. Downstream stalls therefore never lose a state.
//
// Ports
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset
//   flush     : synchronous clear of all buffered entries
//   in_valid  : upstream presents a substituted state
//   in_ready  : stage can accept a state (registered occupancy only)
//   in_data   : 128-bit state, b0 = [127:120] .. b15 = [7:0], b = 4*col + row
//   in_round  : round tag accompanying in_data
//   out_valid : head entry available
//   out_ready : downstream accepts head
//   out_data  : ShiftRows(in_data) of head entry, 0 when out_valid = 0
//   out_round : round tag of head entry, 0 when out_valid = 0
//   count     : occupancy 0..2
// -----------------------------------------------------------------------------
module shift_rows_stage #(
  parameter int ROUND_W = 4,
  parameter int DEPTH   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [127:0]       in_data,
  input  logic [ROUND_W-1:0] in_round,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [127:0]       out_data,
  output logic [ROUND_W-1:0] out_round,
  output logic [1:0]         count
);

  if (DEPTH != 2) begin : g_depth_check
    $error("shift_rows_stage: DEPTH must be 2");
  end

  // Encodings equal the occupancy so count is the state register itself.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               wr_ptr_q, wr_ptr_d;
  logic               rd_ptr_q, rd_ptr_d;
  logic [127:0]       data_q  [2];
  logic [ROUND_W-1:0] round_q [2];

  logic               push, pop;
  logic [127:0]       shifted;

  // Output byte 4c+r takes input byte 4*((c+r) mod 4)+r.
  always_comb begin
    shifted = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        shifted[127 - 8*(4*c + r) -: 8] =
          in_data[127 - 8*(4*((c + r) % 4) + r) -: 8];
      end
    end
  end

  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign count     = state_q;
  assign out_data  = out_valid ? data_q[rd_ptr_q]  : '0;
  assign out_round = out_valid ? round_q[rd_ptr_q] : '0;

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      state_d  = EMPTY;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = ~wr_ptr_q;
      if (pop)  rd_ptr_d = ~rd_ptr_q;
      unique case (state_q)
        EMPTY: if (push) state_d = ONE;
        ONE: begin
          if (push && !pop)      state_d = TWO;
          else if (!push && pop) state_d = EMPTY;
        end
        TWO:     if (pop) state_d = ONE;
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      data_q[0]  <= '0;
      data_q[1]  <= '0;
      round_q[0] <= '0;
      round_q[1] <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (push && !flush) begin
        data_q[wr_ptr_q]  <= shifted;
        round_q[wr_ptr_q] <= in_round;
      end
    end
  end

endmodule
